// File: rtl/volatility_write_ctrl.sv
// Volatility write controller: accepts top-of-book updates, drops zero-price
// updates, and issues one write strobe per update into a per-stock circular
// window of the volatility memory, tracking write pointers and fill levels.
module volatility_write_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int FP_WORD_SIZE = 64,
  parameter int BUFFER_SIZE  = 32,
  parameter int NUM_STOCKS   = 4,
  parameter int ISSUE_GAP    = 2
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset_n,
  input  logic                                        i_update_valid,
  output logic                                        o_update_ready,
  input  logic [$clog2(NUM_STOCKS)-1:0]               i_stock_id,
  input  logic [DATA_WIDTH-1:0]                       i_best_bid,
  input  logic [DATA_WIDTH-1:0]                       i_best_ask,
  input  logic                                        i_clear,
  input  logic [$clog2(NUM_STOCKS)-1:0]               i_clear_stock_id,
  output logic                                        o_valid,
  output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0]   o_write_address,
  output logic [$clog2(NUM_STOCKS)-1:0]               o_stock_id,
  output logic [DATA_WIDTH-1:0]                       o_best_bid,
  output logic [DATA_WIDTH-1:0]                       o_best_ask,
  output logic [DATA_WIDTH-1:0]                       o_buffer_size,
  output logic [FP_WORD_SIZE-1:0]                     o_buffer_size_reciprocal,
  output logic [NUM_STOCKS-1:0]                       o_full_mask,
  output logic [15:0]                                 o_drop_count
);

  localparam int SW = $clog2(NUM_STOCKS);
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int AW = $clog2(NUM_STOCKS * BUFFER_SIZE);
  localparam int FW = $clog2(BUFFER_SIZE + 1);

  localparam logic [FW-1:0] FILL_MAX = FW'(BUFFER_SIZE);
  localparam logic [3:0]    GAP_INIT = (ISSUE_GAP > 0) ? 4'(ISSUE_GAP - 1) : 4'd0;
  localparam logic [FP_WORD_SIZE-1:0] RECIP =
    FP_WORD_SIZE'(64'h1_0000_0000 / 64'(BUFFER_SIZE));

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             gap_q, gap_d;
  logic [PW-1:0]          wp_q [NUM_STOCKS];
  logic [PW-1:0]          wp_d [NUM_STOCKS];
  logic [FW-1:0]          fc_q [NUM_STOCKS];
  logic [FW-1:0]          fc_d [NUM_STOCKS];
  logic [NUM_STOCKS-1:0]  full_q, full_d;
  logic [15:0]            drop_q, drop_d;
  logic                   valid_q, valid_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [SW-1:0]          stock_q, stock_d;
  logic [DATA_WIDTH-1:0]  bid_q, bid_d;
  logic [DATA_WIDTH-1:0]  ask_q, ask_d;
  logic                   accept;
  logic                   zero_price;

  // Fixed window geometry, independent of reset.
  assign o_buffer_size            = DATA_WIDTH'(BUFFER_SIZE);
  assign o_buffer_size_reciprocal = RECIP;

  // Updates are only taken in IDLE, and a pending clear blocks them.
  assign o_update_ready = (state_q == IDLE) && !i_clear;
  assign accept         = i_update_valid && o_update_ready;
  assign zero_price     = (i_best_bid == '0) && (i_best_ask == '0);

  // Next-state, pointer bookkeeping and output latching.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    gap_d   = gap_q;
    wp_d    = wp_q;
    fc_d    = fc_q;
    drop_d  = drop_q;
    valid_d = 1'b0;
    addr_d  = addr_q;
    stock_d = stock_q;
    bid_d   = bid_q;
    ask_d   = ask_q;
    full_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (i_clear) begin
          wp_d[i_clear_stock_id] = '0;
          fc_d[i_clear_stock_id] = '0;
        end else if (accept) begin
          if (zero_price) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end else begin
            stock_d = i_stock_id;
            bid_d   = i_best_bid;
            ask_d   = i_best_ask;
            addr_d  = {i_stock_id, wp_q[i_stock_id]};
            valid_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Power-of-two window: the pointer wraps by natural overflow.
        wp_d[stock_q] = wp_q[stock_q] + 1'b1;
        if (fc_q[stock_q] != FILL_MAX) fc_d[stock_q] = fc_q[stock_q] + 1'b1;
        if (ISSUE_GAP == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          gap_d   = GAP_INIT;
        end
      end
      GAP: begin
        if (gap_q == 4'd0) state_d = IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    for (int s = 0; s < NUM_STOCKS; s++) full_d[s] = (fc_d[s] == FILL_MAX);
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!i_reset_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
      // NOTE: the pointer/fill arrays are small flop arrays that must start
      // at zero, so they are reset here rather than left to a RAM.
      for (int s = 0; s < NUM_STOCKS; s++) begin
        wp_q[s] <= '0;
        fc_q[s] <= '0;
      end
      full_q  <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      stock_q <= '0;
      bid_q   <= '0;
      ask_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wp_q    <= wp_d;
      fc_q    <= fc_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      stock_q <= stock_d;
      bid_q   <= bid_d;
      ask_q   <= ask_d;
    end
  end

  assign o_valid         = valid_q;
  assign o_write_address = addr_q;
  assign o_stock_id      = stock_q;
  assign o_best_bid      = bid_q;
  assign o_best_ask      = ask_q;
  assign o_full_mask     = full_q;
  assign o_drop_count    = drop_q;

endmodule

// File: tb/tb_volatility_write_ctrl.sv
// Self-checking bench for volatility_write_ctrl: a table of single updates
// plus hand-written sequences for wrap/full, clear, reset and back-to-back.
module tb_volatility_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [1:0]  stock_id;
  logic [31:0] bid, ask;
  logic        clr;
  logic [1:0]  clr_id;
  logic        o_valid;
  logic [6:0]  o_addr;
  logic [1:0]  o_stock;
  logic [31:0] o_bid, o_ask, o_bufsize;
  logic [63:0] o_recip;
  logic [3:0]  o_mask;
  logic [15:0] o_drops;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  volatility_write_ctrl dut (
    .i_clk                    (clk),
    .i_reset_n                (rst_n),
    .i_update_valid           (upd_valid),
    .o_update_ready           (upd_ready),
    .i_stock_id               (stock_id),
    .i_best_bid               (bid),
    .i_best_ask               (ask),
    .i_clear                  (clr),
    .i_clear_stock_id         (clr_id),
    .o_valid                  (o_valid),
    .o_write_address          (o_addr),
    .o_stock_id               (o_stock),
    .o_best_bid               (o_bid),
    .o_best_ask               (o_ask),
    .o_buffer_size            (o_bufsize),
    .o_buffer_size_reciprocal (o_recip),
    .o_full_mask              (o_mask),
    .o_drop_count             (o_drops)
  );

  typedef struct {
    logic [1:0]  stock;
    logic [31:0] bid;
    logic [31:0] ask;
    logic [6:0]  addr;
  } sb_t;

  typedef struct {
    logic [1:0]  stock;
    logic [31:0] bid;
    logic [31:0] ask;
    logic [6:0]  addr;
    logic [15:0] drops;
    bit          timing;
  } vec_t;

  sb_t  sb_q [$];
  int   vcyc [$];
  sb_t  mon_e;
  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h expected no write", o_addr);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr",  64'(o_addr),  64'(mon_e.addr));
        check("wr_stock", 64'(o_stock), 64'(mon_e.stock));
        check("wr_bid",   64'(o_bid),   64'(mon_e.bid));
        check("wr_ask",   64'(o_ask),   64'(mon_e.ask));
      end
      vcyc.push_back(cyc);
    end
  end

  // Called at a negedge; returns at the first negedge with ready high.
  task automatic wait_ready(input string name);
    for (int i = 0; i < 50 && upd_ready !== 1'b1; i++) @(negedge clk);
    if (upd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got ready %b expected 1", name, upd_ready);
    end
  endtask

  // Drives one update, pushes its expected write, returns at the negedge
  // after the accepting edge (the ISSUE cycle for a non-zero update).
  task automatic send(input logic [1:0] s, input logic [31:0] b, input logic [31:0] a,
                      input logic [6:0] exp_addr, input bit timing);
    sb_t e;
    @(negedge clk);
    stock_id  = s;
    bid       = b;
    ask       = a;
    upd_valid = 1'b1;
    wait_ready("send");
    @(posedge clk);
    if (!(b == 0 && a == 0)) begin
      e.stock = s; e.bid = b; e.ask = a; e.addr = exp_addr;
      sb_q.push_back(e);
    end
    @(negedge clk);
    upd_valid = 1'b0;
    if (timing) begin
      check("latency_valid", 64'(o_valid), 64'd1);
      check("ready_low_issue", 64'(upd_ready), 64'd0);
      @(negedge clk);
      check("ready_low_gap1", 64'(upd_ready), 64'd0);
      @(negedge clk);
      check("ready_low_gap2", 64'(upd_ready), 64'd0);
      @(negedge clk);
      check("ready_back", 64'(upd_ready), 64'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    upd_valid = 1'b0;
    clr       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; upd_valid = 1'b0; stock_id = '0; bid = '0; ask = '0;
    clr = 1'b0; clr_id = '0;

    vecs[0] = '{2'd2, 32'd100,        32'd102,        7'd64, 16'd0, 1'b1};
    vecs[1] = '{2'd0, 32'd0,          32'd0,          7'd0,  16'd1, 1'b0};
    vecs[2] = '{2'd0, 32'd5,          32'd6,          7'd0,  16'd1, 1'b0};
    vecs[3] = '{2'd3, 32'd7,          32'd8,          7'd96, 16'd1, 1'b0};
    vecs[4] = '{2'd2, 32'd9,          32'd10,         7'd65, 16'd1, 1'b0};
    vecs[5] = '{2'd0, 32'd0,          32'd11,         7'd1,  16'd1, 1'b0};
    vecs[6] = '{2'd1, 32'd12,         32'd0,          7'd32, 16'd1, 1'b0};
    vecs[7] = '{2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  7'd97, 16'd1, 1'b0};
    vecs[8] = '{2'd1, 32'd0,          32'd0,          7'd0,  16'd2, 1'b0};

    // Reset state, with constants checked while reset is held.
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_addr",  64'(o_addr),  64'd0);
    check("rst_bid",   64'(o_bid),   64'd0);
    check("rst_mask",  64'(o_mask),  64'd0);
    check("rst_drops", 64'(o_drops), 64'd0);
    check("bufsize",   64'(o_bufsize), 64'd32);
    check("recip",     o_recip,      64'h0000_0000_0800_0000);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(upd_ready), 64'd1);

    // Table: single updates, zero-price drop, single-zero-side not dropped.
    foreach (vecs[i]) begin
      send(vecs[i].stock, vecs[i].bid, vecs[i].ask, vecs[i].addr, vecs[i].timing);
      check("drop_count", 64'(o_drops), 64'(vecs[i].drops));
    end
    wait_ready("table_end");

    // Wrap and full on stock 1.
    do_reset();
    for (int k = 0; k < 33; k++) begin
      send(2'd1, 32'(k + 1), 32'(k + 2), 7'(32 + (k % 32)), 1'b0);
      if (k >= 30) begin
        wait_ready("wrap");
        check("wrap_mask", 64'(o_mask), (k == 30) ? 64'd0 : 64'd2);
      end
    end

    // Clear beats a concurrent update on a full stock.
    do_reset();
    for (int k = 0; k < 32; k++) send(2'd3, 32'(k + 1), 32'(k + 1000), 7'(96 + k), 1'b0);
    wait_ready("fill3");
    check("full3_mask", 64'(o_mask), 64'd8);
    @(negedge clk);
    clr = 1'b1; clr_id = 2'd3;
    stock_id = 2'd3; bid = 32'd500; ask = 32'd501; upd_valid = 1'b1;
    #1;
    check("ready_low_clear", 64'(upd_ready), 64'd0);
    @(negedge clk);
    clr = 1'b0; upd_valid = 1'b0;
    #1;
    check("clear_mask", 64'(o_mask), 64'd0);
    check("clear_no_write", 64'(o_valid), 64'd0);
    send(2'd3, 32'd600, 32'd601, 7'd96, 1'b0);
    wait_ready("clear_end");

    // Reset during GAP after a stock-0 write.
    do_reset();
    send(2'd3, 32'd0, 32'd0, 7'd0, 1'b0);
    send(2'd0, 32'd55, 32'd66, 7'd0, 1'b0);
    @(negedge clk);
    check("gap_ready_low", 64'(upd_ready), 64'd0);
    check("pre_rst_drops", 64'(o_drops), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("gap_rst_valid", 64'(o_valid), 64'd0);
    check("gap_rst_bid",   64'(o_bid),   64'd0);
    check("gap_rst_ask",   64'(o_ask),   64'd0);
    check("gap_rst_drops", 64'(o_drops), 64'd0);
    check("gap_rst_ready", 64'(upd_ready), 64'd1);
    send(2'd0, 32'd77, 32'd88, 7'd0, 1'b0);
    send(2'd3, 32'd9, 32'd9, 7'd96, 1'b0);

    // Reset during ISSUE.
    send(2'd2, 32'd11, 32'd12, 7'd64, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("issue_rst_ready", 64'(upd_ready), 64'd1);
    check("issue_rst_stock", 64'(o_stock), 64'd0);
    send(2'd2, 32'd13, 32'd14, 7'd64, 1'b0);

    // Back-to-back with valid held high.
    do_reset();
    vcyc.delete();
    @(negedge clk);
    upd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb_t e;
      stock_id = 2'd1; bid = 32'(200 + k); ask = 32'(300 + k);
      wait_ready("b2b");
      @(posedge clk);
      e.stock = 2'd1; e.bid = 32'(200 + k); e.ask = 32'(300 + k); e.addr = 7'(32 + k);
      sb_q.push_back(e);
      @(negedge clk);
    end
    upd_valid = 1'b0;
    wait_ready("b2b_end");
    repeat (2) @(negedge clk);
    check("b2b_pulses", 64'(vcyc.size()), 64'd4);
    for (int k = 1; k < 4 && k < vcyc.size(); k++)
      check("b2b_spacing", 64'(vcyc[k] - vcyc[k-1]), 64'd4);

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/volatility_write_ctrl.md
VOLATILITY_WRITE_CTRL -- requirements
Module: volatility_write_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 32, price width.
- FP_WORD_SIZE, 64, fixed-point word width (Q32.32).
- BUFFER_SIZE, 32, samples per stock window; power of 2.
- NUM_STOCKS, 4, stock count; power of 2.
- ISSUE_GAP, 2, idle cycles after each write (range 0-15).
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk, in, 1, clock.
- i_reset_n, in, 1, synchronous active-low reset.
- i_update_valid, in, 1, upstream top-of-book update valid.
- o_update_ready, out, 1, update accepted when valid and ready are both high.
- i_stock_id, in, clog2(NUM_STOCKS), update stock.
- i_best_bid, in, DATA_WIDTH, best bid.
- i_best_ask, in, DATA_WIDTH, best ask.
- i_clear, in, 1, window clear request.
- i_clear_stock_id, in, clog2(NUM_STOCKS), stock to clear.
- o_valid, out, 1, one-cycle write strobe to the volatility memory.
- o_write_address, out, clog2(NUM_STOCKS*BUFFER_SIZE), buffer slot.
- o_stock_id, out, clog2(NUM_STOCKS), stock of the write.
- o_best_bid, out, DATA_WIDTH, latched bid.
- o_best_ask, out, DATA_WIDTH, latched ask.
- o_buffer_size, out, DATA_WIDTH, constant BUFFER_SIZE.
- o_buffer_size_reciprocal, out, FP_WORD_SIZE, constant 2^32/BUFFER_SIZE (Q32.32).
- o_full_mask, out, NUM_STOCKS, bit s high when stock s window holds BUFFER_SIZE samples.
- o_drop_count, out, 16, count of dropped zero-price updates.
REQ-003 The block SHALL use the single clock i_clk; reset SHALL be synchronous and active-low on i_reset_n.

Function
REQ-004 The block SHALL keep, per stock s, a write pointer wp[s] (0..BUFFER_SIZE-1) and a fill count fc[s] (0..BUFFER_SIZE).
REQ-005 The FSM SHALL have three states: IDLE, ISSUE, GAP.
REQ-006 o_update_ready SHALL equal (state==IDLE) AND NOT i_clear.
REQ-007 In IDLE, an accepted update with i_best_bid==0 and i_best_ask==0 SHALL be dropped: state stays IDLE, o_drop_count increments, saturating at 0xFFFF.
REQ-008 In IDLE, any other accepted update SHALL latch stock, bid and ask, and move to ISSUE.
REQ-009 In ISSUE, o_valid SHALL be 1 for exactly one cycle, with o_write_address = stock*BUFFER_SIZE + wp[stock] and the latched data on o_stock_id/o_best_bid/o_best_ask.
REQ-010 On leaving ISSUE:
- wp[stock] SHALL increment, wrapping BUFFER_SIZE-1 -> 0.
- fc[stock] SHALL increment, saturating at BUFFER_SIZE.
REQ-011 Latency: update accepted at edge N -> o_valid high in the cycle after edge N.
REQ-012 GAP SHALL last ISSUE_GAP cycles, then return to IDLE; if ISSUE_GAP==0, ISSUE SHALL go directly to IDLE. Minimum spacing between accepts is ISSUE_GAP+2 cycles.
REQ-013 Clear in IDLE: i_clear high SHALL zero wp and fc of i_clear_stock_id at the next edge. Clear takes priority over any concurrent update; that update is not accepted.
REQ-014 Clear in ISSUE or GAP SHALL be ignored; the requester holds i_clear until o_update_ready would otherwise be high.
REQ-015 o_full_mask[s] SHALL equal (fc[s]==BUFFER_SIZE), registered.
REQ-016 o_write_address, o_stock_id, o_best_bid and o_best_ask SHALL hold their values outside ISSUE.
REQ-017 o_buffer_size and o_buffer_size_reciprocal SHALL be constants, independent of reset.

Reset
REQ-018 While i_reset_n is low at an edge, the block SHALL:
- set state to IDLE;
- zero all wp, fc, o_full_mask and o_drop_count;
- drive o_valid, o_write_address, o_stock_id, o_best_bid and o_best_ask to 0.
REQ-019 Reset asserted in ISSUE or GAP SHALL abort the write, with no pointer update; o_update_ready SHALL be 1 in the first cycle after reset releases, if i_clear is low.

Verification
REQ-020 Single update: stock 2, bid 100, ask 102 -> o_valid one cycle later, with o_write_address 64, o_stock_id 2, bid 100, ask 102; ready low for 3 cycles (ISSUE_GAP=2).
REQ-021 Wrap/full: 33 updates to stock 1 -> addresses 32..63 then 32; o_full_mask[1] rises after the 32nd write; other mask bits stay 0.
REQ-022 Zero price: bid 0, ask 0 on stock 0 -> no o_valid; o_drop_count 1; wp[0] unchanged (next write to address 0).
REQ-023 Clear vs update: i_clear stock 3 with an update pending -> update not accepted; next stock-3 write goes to address 96; o_full_mask[3] is 0.
REQ-024 Reset mid-GAP: reset pulsed during GAP after a stock-0 write -> all outputs 0; next stock-0 write goes to address 0.
REQ-025 Back-to-back: valid held high with 4 updates -> o_valid pulses exactly 4 cycles apart, with no lost or duplicated update.
